// File: rtl/resampler_ringbuf_array_pkg.sv
// Shared sizing for the per-channel sample history feeding resampler_core.
// resampler_core imports the same values, so offset and sample widths agree by construction.
package resampler_ringbuf_array_pkg;

    localparam int NUM_CH_LOG2    = 3;
    localparam int NUM_CH         = 1 << NUM_CH_LOG2;
    localparam int HALFDEPTH_LOG2 = 4;
    localparam int HALFDEPTH      = 1 << HALFDEPTH_LOG2;
    localparam int DEPTH_LOG2     = 6;
    localparam int DEPTH          = 1 << DEPTH_LOG2;
    localparam int SAMPLE_W       = 24;
    localparam int OFF_W          = HALFDEPTH_LOG2 + 1;
    localparam int CNT_W          = DEPTH_LOG2 + 1;

    // Occupancy change for one cycle, encoded as {push_applied, pop_applied}.
    typedef enum logic [1:0] {
        OP_IDLE = 2'b00,
        OP_POP  = 2'b01,
        OP_PUSH = 2'b10,
        OP_BOTH = 2'b11
    } occ_op_e;

    function automatic logic [DEPTH_LOG2-1:0] ring_addr(input logic [DEPTH_LOG2-1:0] ptr,
                                                        input logic [OFF_W-1:0]      off);
        return ptr + DEPTH_LOG2'(off);
    endfunction

endpackage

// File: rtl/resampler_ringbuf_array_if.sv
// Bus between the input side / resampler_core (master) and the ring buffer array (slave).
interface resampler_ringbuf_array_if;
    import resampler_ringbuf_array_pkg::*;

    // push_i[k]/pop_i[k] are single-cycle strobes, not a valid/ready handshake: the array never
    // stalls. A push while full or a pop while empty is dropped and latched in a sticky flag;
    // the master throttles on count_o/full_o/ready_o instead.
    logic [NUM_CH-1:0]          push_i;
    logic [SAMPLE_W*NUM_CH-1:0] push_data_i;
    logic [NUM_CH-1:0]          pop_i;
    logic [OFF_W*NUM_CH-1:0]    offset_i;
    logic [SAMPLE_W*NUM_CH-1:0] data_o;
    logic [CNT_W*NUM_CH-1:0]    count_o;
    logic [NUM_CH-1:0]          full_o;
    logic [NUM_CH-1:0]          ready_o;
    logic [NUM_CH-1:0]          overflow_o;
    logic [NUM_CH-1:0]          underflow_o;

    modport master (
        output push_i, push_data_i, pop_i, offset_i,
        input  data_o, count_o, full_o, ready_o, overflow_o, underflow_o
    );

    modport slave (
        input  push_i, push_data_i, pop_i, offset_i,
        output data_o, count_o, full_o, ready_o, overflow_o, underflow_o
    );

endinterface

// File: rtl/resampler_ringbuf_array_ringbuf_ch.sv
// One channel of sample history: DEPTH x SAMPLE_W RAM, read/write pointers, occupancy and
// sticky error flags. Window reads are zero-padded beyond the current occupancy.
module resampler_ringbuf_array_ringbuf_ch
    import resampler_ringbuf_array_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                push,
    input  logic [SAMPLE_W-1:0] push_data,
    input  logic                pop,
    input  logic [OFF_W-1:0]    offset,
    output logic [SAMPLE_W-1:0] data,
    output logic [CNT_W-1:0]    count,
    output logic                full,
    output logic                ready,
    output logic                overflow,
    output logic                underflow
);

    logic [SAMPLE_W-1:0]   mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wptr;
    logic [DEPTH_LOG2-1:0] rptr;
    logic [CNT_W-1:0]      count_q;
    logic [CNT_W-1:0]      count_next;
    logic [SAMPLE_W-1:0]   data_q;
    logic                  overflow_q;
    logic                  underflow_q;

    logic                  is_full;
    logic                  is_empty;
    logic                  do_push;
    logic                  do_pop;
    logic [DEPTH_LOG2-1:0] rd_addr;
    logic                  rd_pad;
    occ_op_e               op;

    assign is_full  = (count_q == CNT_W'(DEPTH));
    assign is_empty = (count_q == '0);
    assign do_push  = push && !is_full;
    assign do_pop   = pop && !is_empty;
    assign op       = occ_op_e'({do_push, do_pop});

    // Address uses rptr before this cycle's pop; offsets at or past the occupancy read as zero,
    // which also covers the only case where rd_addr could equal wptr during a push.
    assign rd_addr = ring_addr(rptr, offset);
    assign rd_pad  = (CNT_W'(offset) >= count_q);

    always_comb begin
        count_next = count_q;
        case (op)
            OP_PUSH: count_next = count_q + CNT_W'(1);
            OP_POP:  count_next = count_q - CNT_W'(1);
            default: count_next = count_q;
        endcase
    end

    // RAM contents are deliberately not reset.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wptr] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr        <= '0;
            rptr        <= '0;
            count_q     <= '0;
            data_q      <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            if (do_push) wptr <= wptr + DEPTH_LOG2'(1);
            if (do_pop)  rptr <= rptr + DEPTH_LOG2'(1);
            count_q <= count_next;
            data_q  <= rd_pad ? '0 : mem[rd_addr];
            if (push && is_full) overflow_q  <= 1'b1;
            if (pop && is_empty) underflow_q <= 1'b1;
        end
    end

    assign data      = data_q;
    assign count     = count_q;
    assign full      = is_full;
    assign ready     = (count_q >= CNT_W'(2 * HALFDEPTH));
    assign overflow  = overflow_q;
    assign underflow = underflow_q;

endmodule

// File: rtl/resampler_ringbuf_array.sv
// NUM_CH independent ring buffers; this level only slices the channel buses.
module resampler_ringbuf_array
    import resampler_ringbuf_array_pkg::*;
(
    input  logic                      clk,
    input  logic                      rst_n,
    resampler_ringbuf_array_if.slave  bus
);

    for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
        resampler_ringbuf_array_ringbuf_ch u_ch (
            .clk       (clk),
            .rst_n     (rst_n),
            .push      (bus.push_i[k]),
            .push_data (bus.push_data_i[k*SAMPLE_W +: SAMPLE_W]),
            .pop       (bus.pop_i[k]),
            .offset    (bus.offset_i[k*OFF_W +: OFF_W]),
            .data      (bus.data_o[k*SAMPLE_W +: SAMPLE_W]),
            .count     (bus.count_o[k*CNT_W +: CNT_W]),
            .full      (bus.full_o[k]),
            .ready     (bus.ready_o[k]),
            .overflow  (bus.overflow_o[k]),
            .underflow (bus.underflow_o[k])
        );
    end

endmodule

// File: tb/tb_resampler_ringbuf_array.sv
// Directed bench for resampler_ringbuf_array: fill/read sweeps, full/empty boundaries,
// steady-state push+pop with wrap, and asynchronous reset mid-stream.
module tb_resampler_ringbuf_array;
    import resampler_ringbuf_array_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    resampler_ringbuf_array_if bus ();

    resampler_ringbuf_array dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    // Clock/reset
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    logic [SAMPLE_W-1:0] exp_q[$];
    logic [SAMPLE_W-1:0] exp_d;

    // Driver tasks
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.push_i = '0;
        bus.pop_i  = '0;
    endtask

    task automatic drive_push(input int k, input logic [SAMPLE_W-1:0] d);
        bus.push_i[k] = 1'b1;
        bus.push_data_i[k*SAMPLE_W +: SAMPLE_W] = d;
    endtask

    task automatic set_offset(input int k, input int o);
        bus.offset_i[k*OFF_W +: OFF_W] = OFF_W'(o);
    endtask

    function automatic logic [CNT_W-1:0] ch_count(input int k);
        return bus.count_o[k*CNT_W +: CNT_W];
    endfunction

    function automatic logic [SAMPLE_W-1:0] ch_data(input int k);
        return bus.data_o[k*SAMPLE_W +: SAMPLE_W];
    endfunction

    // Scoreboard comparison
    task automatic chk(input string tag, input logic [191:0] obs, input logic [191:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, " data"},  192'(bus.data_o), 192'(0));
        chk({tag, " count"}, 192'(bus.count_o), 192'(0));
        chk({tag, " full"},  192'(bus.full_o), 192'(0));
        chk({tag, " ready"}, 192'(bus.ready_o), 192'(0));
        chk({tag, " ovf"},   192'(bus.overflow_o), 192'(0));
        chk({tag, " unf"},   192'(bus.underflow_o), 192'(0));
    endtask

    initial begin
        bus.push_i      = '0;
        bus.push_data_i = '0;
        bus.pop_i       = '0;
        bus.offset_i    = '0;

        // Reset state
        #12;
        chk_all_zero("reset");
        rst_n = 1'b1;
        tick();

        // ch0: push 1..32, ready only once the full window is present
        for (int i = 1; i <= 32; i++) begin
            drive_push(0, SAMPLE_W'(i));
            tick();
            if (i == 31) begin
                chk("ch0 ready at 31", 192'(bus.ready_o[0]), 192'(0));
            end
        end
        idle();
        chk("ch0 count 32", 192'(ch_count(0)), 192'(32));
        chk("ch0 ready", 192'(bus.ready_o[0]), 192'(1));
        chk("other counts", 192'(bus.count_o[CNT_W*NUM_CH-1:CNT_W]), 192'(0));

        // ch0: offset sweep, one cycle latency
        for (int i = 0; i < 32; i++) begin
            set_offset(0, i);
            tick();
            chk($sformatf("ch0 off %0d", i), 192'(ch_data(0)), 192'(i + 1));
        end

        // ch0: pop once, then zero padding at offset == count
        bus.pop_i[0] = 1'b1;
        tick();
        idle();
        chk("ch0 count 31", 192'(ch_count(0)), 192'(31));
        set_offset(0, 31);
        tick();
        chk("ch0 pad off31", 192'(ch_data(0)), 192'(0));
        set_offset(0, 30);
        tick();
        chk("ch0 off30 after pop", 192'(ch_data(0)), 192'(32));
        set_offset(0, 0);

        // ch3: fill to 64, overflow on the 65th push
        for (int i = 0; i < 64; i++) begin
            drive_push(3, SAMPLE_W'(100 + i));
            tick();
        end
        chk("ch3 count 64", 192'(ch_count(3)), 192'(64));
        chk("ch3 full", 192'(bus.full_o[3]), 192'(1));
        chk("ch3 ovf before", 192'(bus.overflow_o[3]), 192'(0));
        drive_push(3, SAMPLE_W'(999));
        tick();
        idle();
        chk("ch3 count held", 192'(ch_count(3)), 192'(64));
        chk("ch3 ovf", 192'(bus.overflow_o[3]), 192'(1));
        tick();
        chk("ch3 oldest intact", 192'(ch_data(3)), 192'(100));
        bus.pop_i[3] = 1'b1;
        tick();
        idle();
        chk("ch3 count 63", 192'(ch_count(3)), 192'(63));
        chk("ch3 not full", 192'(bus.full_o[3]), 192'(0));
        chk("ch3 ovf sticky", 192'(bus.overflow_o[3]), 192'(1));

        // ch5: pop while empty, then a push still lands at rptr
        bus.pop_i[5] = 1'b1;
        tick();
        idle();
        chk("ch5 unf", 192'(bus.underflow_o[5]), 192'(1));
        chk("ch5 count 0", 192'(ch_count(5)), 192'(0));
        drive_push(5, 24'h7FFFFF);
        tick();
        idle();
        chk("ch5 count 1", 192'(ch_count(5)), 192'(1));
        tick();
        chk("ch5 off0", 192'(ch_data(5)), 192'(24'h7FFFFF));
        set_offset(5, 1);
        tick();
        chk("ch5 pad off1", 192'(ch_data(5)), 192'(0));
        set_offset(5, 0);

        // ch1: prefill 40, then 100 cycles of push+pop across the pointer wrap
        for (int i = 0; i < 40; i++) begin
            drive_push(1, SAMPLE_W'(1000 + i));
            exp_q.push_back(SAMPLE_W'(1000 + i));
            tick();
        end
        idle();
        chk("ch1 count 40", 192'(ch_count(1)), 192'(40));
        for (int j = 0; j < 100; j++) begin
            exp_d = exp_q[0];
            drive_push(1, SAMPLE_W'(1040 + j));
            exp_q.push_back(SAMPLE_W'(1040 + j));
            bus.pop_i[1] = 1'b1;
            tick();
            chk($sformatf("ch1 step %0d data", j), 192'(ch_data(1)), 192'(exp_d));
            chk($sformatf("ch1 step %0d count", j), 192'(ch_count(1)), 192'(40));
            void'(exp_q.pop_front());
        end
        idle();

        // Asynchronous reset in the middle of traffic on all channels
        for (int k = 0; k < NUM_CH; k++) drive_push(k, SAMPLE_W'(24'h00AA00 + k));
        tick();
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        chk_all_zero("async reset");
        idle();
        #3;
        rst_n = 1'b1;
        tick();

        // Behaviour after release matches power-up
        drive_push(2, 24'h123456);
        tick();
        idle();
        chk("post-reset ch2 count", 192'(ch_count(2)), 192'(1));
        tick();
        chk("post-reset ch2 addr0", 192'(ch_data(2)), 192'(24'h123456));
        bus.pop_i[2] = 1'b1;
        tick();
        idle();
        chk("post-reset ch2 pop", 192'(ch_count(2)), 192'(0));
        chk("post-reset unf", 192'(bus.underflow_o), 192'(0));
        bus.pop_i[2] = 1'b1;
        tick();
        idle();
        chk("post-reset ch2 unf", 192'(bus.underflow_o), 192'(8'h04));

        // Final report
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
